// File: rtl/demux_1t2_buf.sv
// -----------------------------------------------------------------------------
// demux_1t2_buf
//
// Buffered 1-to-2 demultiplexer. One valid/ready byte stream arrives with a
// per-beat channel select. Each accepted beat goes into one of two independent
// circular FIFOs. Each FIFO drains through its own valid/ready port, so a
// stalled consumer on one channel never blocks traffic to the other.
//
// Parameters
//   WIDTH    data width of every beat
//   DEPTH    entries per channel FIFO (power of two, >= 2)
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_data, in_sel     incoming beat and its destination channel (0 or 1)
//   in_valid, in_ready  input handshake; in_ready = selected channel not full
//   o0_data/o0_valid    channel 0 head entry (0 when empty) and non-empty flag
//   o0_ready            channel 0 consumer accepts the head
//   o1_data/o1_valid    channel 1 head entry (0 when empty) and non-empty flag
//   o1_ready            channel 1 consumer accepts the head
//   cnt0, cnt1          per-channel occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module demux_1t2_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         o0_data,
    output logic                     o0_valid,
    input  logic                     o0_ready,
    output logic [WIDTH-1:0]         o1_data,
    output logic                     o1_valid,
    input  logic                     o1_ready,
    output logic [$clog2(DEPTH):0]   cnt0,
    output logic [$clog2(DEPTH):0]   cnt1
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Per-channel status gathered into packed vectors so the shared input
    // handshake can index them by in_sel.
    logic [1:0]            full;
    logic [1:0]            valid;
    logic [1:0]            out_ready;
    logic [1:0][CW-1:0]    cnt;
    logic [1:0][WIDTH-1:0] head;

    assign out_ready = {o1_ready, o0_ready};

    // Depends only on registered occupancy and in_sel: a full channel never
    // accepts a beat, even in a cycle where its consumer is popping.
    assign in_ready = ~full[in_sel];

    genvar k;
    generate
        for (k = 0; k < 2; k++) begin : g_ch
            logic [WIDTH-1:0] mem [DEPTH];
            logic [AW-1:0]    wptr;
            logic [AW-1:0]    rptr;
            logic [CW-1:0]    occ;
            logic             push;
            logic             pop;
            logic [WIDTH-1:0] head_d;

            assign push = in_valid && in_ready && (in_sel == 1'(k));
            assign pop  = (occ != '0) && out_ready[k];

            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wptr <= '0;
                    rptr <= '0;
                    occ  <= '0;
                end else begin
                    // Pointers wrap naturally because DEPTH is a power of two.
                    if (push) wptr <= wptr + AW'(1);
                    if (pop)  rptr <= rptr + AW'(1);
                    case ({push, pop})
                        2'b10:   occ <= occ + CW'(1);
                        2'b01:   occ <= occ - CW'(1);
                        default: occ <= occ;
                    endcase
                end
            end

            // NOTE: the storage array has no reset; stale contents are never
            // visible because the head is forced to 0 whenever occ is 0.
            always_ff @(posedge clk) begin
                if (push) mem[wptr] <= in_data;
            end

            // NOTE: the default is assigned first so no path leaves head_d
            // unassigned, which would otherwise infer a latch.
            always_comb begin
                head_d = '0;
                if (occ != '0) head_d = mem[rptr];
            end

            assign full[k]  = (occ == CW'(DEPTH));
            assign valid[k] = (occ != '0);
            assign cnt[k]   = occ;
            assign head[k]  = head_d;
        end
    endgenerate

    assign o0_data  = head[0];
    assign o0_valid = valid[0];
    assign cnt0     = cnt[0];
    assign o1_data  = head[1];
    assign o1_valid = valid[1];
    assign cnt1     = cnt[1];

endmodule

// File: tb/tb_demux_1t2_buf.sv
// -----------------------------------------------------------------------------
// tb_demux_1t2_buf
//
// Self-checking bench for demux_1t2_buf. The driver issues one beat per cycle
// and, when the beat is accepted, pushes it onto the expected queue of its
// channel. A monitor on the falling edge compares every channel output with the
// head of its queue, pops the queue on each consumer handshake, and checks
// in_ready and occupancy against the queue sizes.
// -----------------------------------------------------------------------------
module tb_demux_1t2_buf;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] o0_data;
    logic             o0_valid;
    logic             o0_ready;
    logic [WIDTH-1:0] o1_data;
    logic             o1_valid;
    logic             o1_ready;
    logic [CW-1:0]    cnt0;
    logic [CW-1:0]    cnt1;

    demux_1t2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .o0_data  (o0_data),
        .o0_valid (o0_valid),
        .o0_ready (o0_ready),
        .o1_data  (o1_data),
        .o1_valid (o1_valid),
        .o1_ready (o1_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue of pending beats per channel.
    logic [WIDTH-1:0] exp_q [2][$];
    int               pop_cnt [2];
    int               n_checks;
    int               n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_chan(input int k, input logic v, input logic [WIDTH-1:0] d,
                              input logic [CW-1:0] c, input logic rdy);
        int sz;
        sz = exp_q[k].size();
        check($sformatf("o%0d_valid", k), 32'(v), 32'(sz != 0));
        check($sformatf("cnt%0d", k), 32'(c), 32'(sz));
        if (sz != 0) check($sformatf("o%0d_data", k), 32'(d), 32'(exp_q[k][0]));
        else         check($sformatf("o%0d_data_empty", k), 32'(d), 32'(0));
        if (rdy && sz != 0) begin
            void'(exp_q[k].pop_front());
            pop_cnt[k]++;
        end
    endtask

    // Monitor: outputs are stable at the falling edge; the model state here
    // reflects all handshakes up to the preceding rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", 32'(in_ready), 32'(exp_q[int'(in_sel)].size() < DEPTH));
            check_chan(0, o0_valid, o0_data, cnt0, o0_ready);
            check_chan(1, o1_valid, o1_data, cnt1, o1_ready);
        end
    end

    // One cycle of stimulus: drive after the rising edge, then record the
    // beat as issued if it will be accepted at the next rising edge.
    task automatic cycle(input logic v, input logic s, input logic [WIDTH-1:0] d,
                         input logic r0, input logic r1);
        @(posedge clk);
        #1;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        o0_ready = r0;
        o1_ready = r1;
        @(negedge clk);
        #1;
        if (rst_n && in_valid && in_ready) exp_q[int'(in_sel)].push_back(in_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        n_checks = 0;
        n_fail   = 0;
        pop_cnt[0] = 0;
        pop_cnt[1] = 0;
        rst_n    = 1'b0;
        in_data  = '0;
        in_sel   = 1'b0;
        in_valid = 1'b0;
        o0_ready = 1'b0;
        o1_ready = 1'b0;

        #2;
        check("por_in_ready", 32'(in_ready), 32'(1));
        check("por_cnt0", 32'(cnt0), 32'(0));
        check("por_o1_valid", 32'(o1_valid), 32'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Steering: one beat to each channel with both consumers stalled.
        cycle(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("steer_cnt0", 32'(cnt0), 32'(1));
        check("steer_cnt1", 32'(cnt1), 32'(1));
        check("steer_o0_data", 32'(o0_data), 32'h A5);
        check("steer_o1_data", 32'(o1_data), 32'h 3C);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Full and backpressure on channel 0.
        cycle(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'(0));
        check("full_cnt0", 32'(cnt0), 32'(2));
        in_sel = 1'b1;
        #1 check("switch_sel_ready", 32'(in_ready), 32'(1));
        in_sel = 1'b0;
        #1 check("switch_back_ready", 32'(in_ready), 32'(0));
        cycle(1'b1, 1'b0, 8'h33, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        check("after_pop_head", 32'(o0_data), 32'h 22);
        check("after_pop_ready", 32'(in_ready), 32'(1));
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous push and pop on channel 1.
        cycle(1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h02, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("pushpop_cnt1", 32'(cnt1), 32'(1));
        check("pushpop_o1_data", 32'(o1_data), 32'h 02);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Wrap-around streaming through channel 0.
        base = pop_cnt[0];
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 8'(i), 1'b1, 1'b0);
            check("stream_cnt0_le1", 32'(cnt0 <= 1), 32'(1));
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("stream_beats_out", 32'(pop_cnt[0] - base), 32'(16));

        // Pop attempts on an empty channel 1, then a push must read back.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("empty_pop_cnt1", 32'(cnt1), 32'(0));
        check("empty_pop_valid", 32'(o1_valid), 32'(0));
        cycle(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("empty_pop_readback", 32'(o1_data), 32'h 5A);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 4));
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("drain_q0_empty", 32'(exp_q[0].size()), 32'(0));
        check("drain_q1_empty", 32'(exp_q[1].size()), 32'(0));

        // Asynchronous reset with both channels holding data.
        cycle(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h78, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h79, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h7A, 1'b0, 1'b0);
        check("prerst_in_ready", 32'(in_ready), 32'(0));
        #2 rst_n = 1'b0;
        #1;
        check("rst_o0_valid", 32'(o0_valid), 32'(0));
        check("rst_o1_valid", 32'(o1_valid), 32'(0));
        check("rst_cnt0", 32'(cnt0), 32'(0));
        check("rst_cnt1", 32'(cnt1), 32'(0));
        check("rst_o0_data", 32'(o0_data), 32'(0));
        check("rst_o1_data", 32'(o1_data), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        exp_q[0].delete();
        exp_q[1].delete();
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        cycle(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("postrst_o1_data", 32'(o1_data), 32'h C3);
        check("postrst_cnt0", 32'(cnt0), 32'(0));
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("final_q1_empty", 32'(exp_q[1].size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
